sc_spi_rxfifo: RTL and testbench
================================

Name: sc_spi_rxfifo

Overview:
- Receive-side data buffer directly downstream of the SPI protocol engine.
- Captures each 32-bit RX word the engine presents (RXDATA/RXVALID, already re-timed to SYSCLK) into a synchronous FIFO.
- Presents the words to the register block through a first-word-fall-through read port.
- Generates status (count, empty/full, sticky overflow, transfer done) and a level interrupt request.

Parameters:
- DEPTH, 16, number of 32-bit entries; power of two, 2..256.
- AW, 4, address width; must equal log2(DEPTH).

Ports:
- SYSCLK  input  1  system clock; all logic on rising edge.
- SYSRST  input  1  synchronous, active-high reset.
- RXDATA  input  32  receive word from engine, already byte-ordered.
- RXVALID  input  1  one-cycle SYSCLK pulse; RXDATA valid in the same cycle.
- SPICOMPLETE  input  1  one-cycle pulse at end of an SPI transfer.
- RXRDEN  input  1  register-side pop request.
- RXCLR  input  1  one-cycle flush request.
- RXTHRESH  input  AW+1  interrupt threshold in entries; 0 disables the threshold term.
- RXRDATA  output  32  head entry (FWFT); 0 when empty.
- RXCOUNT  output  AW+1  entries held, 0..DEPTH.
- RXEMPTY  output  1  RXCOUNT==0.
- RXFULL  output  1  RXCOUNT==DEPTH.
- RXOVF  output  1  sticky overflow flag.
- RXDONE  output  1  sticky transfer-complete flag.
- RXIRQ  output  1  level interrupt request.

Behaviour:
- Storage: DEPTH x 32 register array. Write pointer WP and read pointer RP, each AW bits, wrap modulo DEPTH. Separate count register (AW+1 bits).
- Reset (SYSRST=1 at a clock edge): WP=RP=0, RXCOUNT=0, RXOVF=0, RXDONE=0.
  - Output values during reset: RXEMPTY=1, RXFULL=0, RXRDATA=0, RXIRQ=0.
  - Array contents are not reset.
  - Reset overrides every other input in the same cycle.
- Write: RXVALID=1 and not full → mem[WP]<=RXDATA, WP+1, count+1.
- Write when full: word dropped, pointers and count unchanged, RXOVF<=1.
- Read: RXRDEN=1 and not empty → RP+1, count−1. The next head is visible on RXRDATA the following cycle.
- Read when empty: ignored, no error.
- RXRDATA is combinational from mem[RP], gated to 0 when empty. Latency from write to visibility on RXRDATA is 1 cycle.
- Simultaneous write and read:
  - Not empty and not full: both occur, count unchanged.
  - Empty: only the write occurs; the read is ignored.
  - Full: both occur; the write is accepted because the read frees the slot. RXOVF is not set.
- RXCLR=1: WP=RP=0, count=0, RXOVF=0, RXDONE=0.
  - Any RXVALID, RXRDEN or SPICOMPLETE in the same cycle is discarded.
  - RXCLR has lower priority than SYSRST.
- RXDONE:
  - Set on SPICOMPLETE.
  - Cleared only by RXCLR or reset.
  - If SPICOMPLETE and RXVALID arrive in the same cycle, the word is written and RXDONE is set. Both take effect on the same edge.
- RXOVF is cleared only by RXCLR or reset.
- RXIRQ (registered, updated each cycle from next-state values) = (RXTHRESH!=0 and next_count>=RXTHRESH) or next_RXOVF or (next_RXDONE and next_count!=0).
- RXTHRESH>DEPTH: the threshold term never fires.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble. Ordering is strict FIFO across wrap.
- No combinational path from RXRDEN to any output other than through registers. RXRDATA depends only on RP, count and the array.

Test Plan:
1. Reset, then 3 RXVALID pulses with 0x11111111, 0x22222222, 0x33333333 → RXCOUNT=3, RXRDATA=0x11111111. Three RXRDEN pops return the words in order. RXEMPTY=1 after the third pop, RXRDATA=0.
2. Write 17 words (0x100+i) with DEPTH=16, no reads → RXFULL=1 at 16 and RXOVF=1 after the 17th. Pops return 0x100..0x10F; 0x110 is absent. RXOVF stays 1 until a RXCLR pulse clears it.
3. With 16 words held, assert RXVALID(0xAAAA5555) and RXRDEN together → RXCOUNT remains 16, RXOVF=0. The 16th pop afterwards returns 0xAAAA5555.
4. RXTHRESH=4: write 3 words → RXIRQ=0. Write the 4th → RXIRQ=1 on the following cycle. Pop one → RXIRQ=0.
5. SPICOMPLETE and RXVALID(0xDEADBEEF) in the same cycle → RXDONE=1, RXCOUNT=1, RXIRQ=1. Pop → RXIRQ=0 with RXDONE still 1. RXCLR → RXDONE=0.
6. 40 write/read pairs, interleaved, across pointer wrap → data order intact, no overflow. Assert SYSRST mid-stream with RXCOUNT=5 → all status returns to reset values on the next cycle.

Source files
------------

// File: rtl/sc_spi_rxfifo_if.sv
`default_nettype none
// ============================================================================
// Module   : sc_spi_rxfifo_if
// Purpose  : Bundles the engine write side, register-side read port and
//            status lines of the SPI receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface sc_spi_rxfifo_if #(
    parameter int AW = 4
);
    logic [31:0] RXDATA;
    logic        RXVALID;
    logic        SPICOMPLETE;
    logic        RXRDEN;
    logic        RXCLR;
    logic [AW:0] RXTHRESH;
    logic [31:0] RXRDATA;
    logic [AW:0] RXCOUNT;
    logic        RXEMPTY;
    logic        RXFULL;
    logic        RXOVF;
    logic        RXDONE;
    logic        RXIRQ;

    modport master (
        output RXDATA, RXVALID, SPICOMPLETE, RXRDEN, RXCLR, RXTHRESH,
        input  RXRDATA, RXCOUNT, RXEMPTY, RXFULL, RXOVF, RXDONE, RXIRQ
    );

    modport slave (
        input  RXDATA, RXVALID, SPICOMPLETE, RXRDEN, RXCLR, RXTHRESH,
        output RXRDATA, RXCOUNT, RXEMPTY, RXFULL, RXOVF, RXDONE, RXIRQ
    );
endinterface
`default_nettype wire

// File: rtl/sc_spi_rxfifo.sv
`default_nettype none
// ============================================================================
// Module   : sc_spi_rxfifo
// Purpose  : SPI receive FIFO with first-word-fall-through read port,
//            sticky overflow/done flags and a registered level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module sc_spi_rxfifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  wire logic         SYSCLK,
    input  wire logic         SYSRST,
    sc_spi_rxfifo_if.slave    bus
);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          r_done;
    logic          r_irq;

    logic          w_empty;
    logic          w_full;
    logic          w_rd;
    logic          w_wr;
    logic          w_ovf_set;
    logic [AW:0]   w_count_nxt;
    logic          w_ovf_nxt;
    logic          w_done_nxt;
    logic          w_irq_nxt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);

    // A read from a full FIFO frees the slot the concurrent write lands in.
    assign w_rd      = bus.RXRDEN  && !w_empty;
    assign w_wr      = bus.RXVALID && (!w_full || w_rd);
    assign w_ovf_set = bus.RXVALID && w_full && !w_rd;

    always_comb begin
        w_count_nxt = r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        w_ovf_nxt   = r_ovf  || w_ovf_set;
        w_done_nxt  = r_done || bus.SPICOMPLETE;
        if (bus.RXCLR) begin
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
            w_done_nxt  = 1'b0;
        end
        w_irq_nxt = ((bus.RXTHRESH != '0) && (w_count_nxt >= bus.RXTHRESH))
                  || w_ovf_nxt
                  || (w_done_nxt && (w_count_nxt != '0));
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (bus.RXCLR) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                if (w_wr) r_wp <= r_wp + AW'(1);
                if (w_rd) r_rp <= r_rp + AW'(1);
            end
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_done  <= w_done_nxt;
            r_irq   <= w_irq_nxt;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge SYSCLK) begin
        if (!SYSRST && !bus.RXCLR && w_wr) begin
            r_mem[r_wp] <= bus.RXDATA;
        end
    end

    assign bus.RXRDATA = w_empty ? 32'h0 : r_mem[r_rp];
    assign bus.RXCOUNT = r_count;
    assign bus.RXEMPTY = w_empty;
    assign bus.RXFULL  = w_full;
    assign bus.RXOVF   = r_ovf;
    assign bus.RXDONE  = r_done;
    assign bus.RXIRQ   = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_sc_spi_rxfifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_spi_rxfifo
// Purpose  : Directed vector table plus hand sequences for sc_spi_rxfifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_spi_rxfifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    sc_spi_rxfifo_if #(.AW(4)) bus();

    sc_spi_rxfifo #(.DEPTH(16), .AW(4)) dut (
        .SYSCLK (clk),
        .SYSRST (rst),
        .bus    (bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] d;
        logic        rd;
        logic        clr;
        logic        spic;
        logic [4:0]  th;
        logic [4:0]  c;
        logic [31:0] q;
        logic        e;
        logic        f;
        logic        o;
        logic        dn;
        logic        irq;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [31:0] d, input logic rd,
                         input logic clr, input logic spic);
        bus.RXVALID     = wr;
        bus.RXDATA      = d;
        bus.RXRDEN      = rd;
        bus.RXCLR       = clr;
        bus.SPICOMPLETE = spic;
        @(posedge clk);
        #1;
        bus.RXVALID     = 1'b0;
        bus.RXRDEN      = 1'b0;
        bus.RXCLR       = 1'b0;
        bus.SPICOMPLETE = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic [4:0] c, input logic [31:0] q,
                              input logic e, input logic f, input logic o,
                              input logic dn, input logic irq);
        chk({tag, ".count"}, 32'(bus.RXCOUNT), 32'(c));
        chk({tag, ".rdata"}, bus.RXRDATA, q);
        chk({tag, ".empty"}, 32'(bus.RXEMPTY), 32'(e));
        chk({tag, ".full"},  32'(bus.RXFULL),  32'(f));
        chk({tag, ".ovf"},   32'(bus.RXOVF),   32'(o));
        chk({tag, ".done"},  32'(bus.RXDONE),  32'(dn));
        chk({tag, ".irq"},   32'(bus.RXIRQ),   32'(irq));
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] w;

        //            wr d             rd clr sp th  c  q             e f o d i
        tbl[0]  = '{0, 32'h0,        0, 0, 0, 0,  0, 32'h0,        1,0,0,0,0};
        tbl[1]  = '{1, 32'h11111111, 0, 0, 0, 0,  1, 32'h11111111, 0,0,0,0,0};
        tbl[2]  = '{1, 32'h22222222, 0, 0, 0, 0,  2, 32'h11111111, 0,0,0,0,0};
        tbl[3]  = '{1, 32'h33333333, 0, 0, 0, 0,  3, 32'h11111111, 0,0,0,0,0};
        tbl[4]  = '{0, 32'h0,        1, 0, 0, 0,  2, 32'h22222222, 0,0,0,0,0};
        tbl[5]  = '{0, 32'h0,        1, 0, 0, 0,  1, 32'h33333333, 0,0,0,0,0};
        tbl[6]  = '{0, 32'h0,        1, 0, 0, 0,  0, 32'h0,        1,0,0,0,0};
        tbl[7]  = '{0, 32'h0,        1, 0, 0, 0,  0, 32'h0,        1,0,0,0,0};
        tbl[8]  = '{1, 32'hA1,       0, 0, 0, 4,  1, 32'hA1,       0,0,0,0,0};
        tbl[9]  = '{1, 32'hA2,       0, 0, 0, 4,  2, 32'hA1,       0,0,0,0,0};
        tbl[10] = '{1, 32'hA3,       0, 0, 0, 4,  3, 32'hA1,       0,0,0,0,0};
        tbl[11] = '{1, 32'hA4,       0, 0, 0, 4,  4, 32'hA1,       0,0,0,0,1};
        tbl[12] = '{0, 32'h0,        1, 0, 0, 4,  3, 32'hA2,       0,0,0,0,0};
        tbl[13] = '{0, 32'h0,        0, 1, 0, 0,  0, 32'h0,        1,0,0,0,0};
        tbl[14] = '{1, 32'hDEADBEEF, 0, 0, 1, 0,  1, 32'hDEADBEEF, 0,0,0,1,1};
        tbl[15] = '{0, 32'h0,        1, 0, 0, 0,  0, 32'h0,        1,0,0,1,0};
        tbl[16] = '{0, 32'h0,        0, 1, 0, 0,  0, 32'h0,        1,0,0,0,0};
        tbl[17] = '{1, 32'h77,       1, 1, 1, 0,  0, 32'h0,        1,0,0,0,0};
        tbl[18] = '{1, 32'h5,        0, 0, 0, 17, 1, 32'h5,        0,0,0,0,0};
        tbl[19] = '{0, 32'h0,        0, 0, 1, 0,  1, 32'h5,        0,0,0,1,1};
        tbl[20] = '{0, 32'h0,        0, 1, 0, 0,  0, 32'h0,        1,0,0,0,0};

        bus.RXDATA = '0; bus.RXVALID = 0; bus.RXRDEN = 0;
        bus.RXCLR = 0; bus.SPICOMPLETE = 0; bus.RXTHRESH = '0;
        drive(1, 32'h99, 1, 0, 1);
        drive(0, 0, 0, 0, 0);
        chk_status("reset", 0, 32'h0, 1, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            bus.RXTHRESH = tbl[i].th;
            drive(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].clr, tbl[i].spic);
            chk_status($sformatf("vec%0d", i), tbl[i].c, tbl[i].q,
                       tbl[i].e, tbl[i].f, tbl[i].o, tbl[i].dn, tbl[i].irq);
        end
        bus.RXTHRESH = '0;

        // Overflow: 17 writes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            drive(1, 32'h100 + i, 0, 0, 0);
            if (i == 15) chk_status("fill16", 16, 32'h100, 0, 1, 0, 0, 0);
        end
        chk_status("ovf17", 16, 32'h100, 0, 1, 1, 0, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovfpop%0d", i), bus.RXRDATA, 32'h100 + i);
            drive(0, 0, 1, 0, 0);
        end
        chk_status("ovfdrain", 0, 32'h0, 1, 0, 1, 0, 1);
        drive(0, 0, 0, 1, 0);
        chk_status("ovfclr", 0, 32'h0, 1, 0, 0, 0, 0);

        // Simultaneous write and read while full
        for (int i = 0; i < 16; i++) drive(1, 32'h200 + i, 0, 0, 0);
        drive(1, 32'hAAAA5555, 1, 0, 0);
        chk_status("fullrw", 16, 32'h201, 0, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            w = (i == 15) ? 32'hAAAA5555 : 32'h201 + i;
            chk($sformatf("fullrwpop%0d", i), bus.RXRDATA, w);
            drive(0, 0, 1, 0, 0);
        end
        chk_status("fullrwdrain", 0, 32'h0, 1, 0, 0, 0, 0);

        // Interleaved traffic across pointer wrap
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h3000 + i, 0, 0, 0);
            q.push_back(32'h3000 + i);
        end
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("wrap%0d", k), bus.RXRDATA, q[0]);
            w = 32'h3100 + k;
            drive(1, w, 1, 0, 0);
            void'(q.pop_front());
            q.push_back(w);
        end
        chk_status("wrapend", 3, q[0], 0, 0, 0, 0, 0);
        drive(1, 32'h3200, 0, 0, 0);
        drive(1, 32'h3201, 0, 0, 0);
        chk_status("pre_rst", 5, q[0], 0, 0, 0, 0, 0);

        rst = 1'b1;
        drive(1, 32'h3300, 1, 0, 1);
        chk_status("midrst", 0, 32'h0, 1, 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk_status("postrst", 0, 32'h0, 1, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
